// File: rtl/dac_interleaver.sv
// -----------------------------------------------------------------------------
// dac_interleaver
//
// Feeds the two-channel DAC port. Paired A/B samples arrive over a valid/ready
// handshake and are buffered in a small frame FIFO. Each sample is saturated to
// the DAC range, offset-encoded, and time-multiplexed onto one DAC data bus
// with a channel select and an active-low write strobe. When the source stalls
// the last frame is re-presented and each such underrun is flagged and counted.
//
// Ports
//   dac_clk_i    : DAC clock (only clock in this block)
//   dac_rst_i    : asynchronous active-high reset
//   s_dat_a_i    : channel A sample, signed IW bits
//   s_dat_b_i    : channel B sample, signed IW bits
//   s_valid_i    : source has a frame (A+B pair) available
//   s_ready_o    : FIFO has room for a frame
//   ch_en_i      : per-channel enable, bit 0 = A, bit 1 = B
//   dac_dat_o    : encoded DAC word
//   dac_sel_o    : 0 = channel A word, 1 = channel B word
//   dac_wrt_o    : write strobe, active low
//   underflow_o  : one-cycle pulse per underrun
//   urun_cnt_o   : saturating underrun count
//
// IW must be larger than DW; FIFO_DEPTH must be a power of 2, at least 2.
// -----------------------------------------------------------------------------
module dac_interleaver #(
    parameter int DW         = 14,
    parameter int IW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          dac_clk_i,
    input  logic          dac_rst_i,
    input  logic [IW-1:0] s_dat_a_i,
    input  logic [IW-1:0] s_dat_b_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [1:0]    ch_en_i,
    output logic [DW-1:0] dac_dat_o,
    output logic          dac_sel_o,
    output logic          dac_wrt_o,
    output logic          underflow_o,
    output logic [15:0]   urun_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    // Encoded mid-scale (zero) word, also the idle/disabled output.
    localparam logic [DW-1:0] ENC_ZERO = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PH_A,
        ST_PH_B
    } state_t;

    // Clamp a signed IW-bit sample to the signed DW-bit range. The value fits
    // when all bits above the DW-bit sign bit match the input sign.
    function automatic logic [DW-1:0] sat(input logic [IW-1:0] x);
        if (!x[IW-1] && (|x[IW-2:DW-1])) begin
            return {1'b0, {(DW-1){1'b1}}};
        end else if (x[IW-1] && !(&x[IW-2:DW-1])) begin
            return {1'b1, {(DW-1){1'b0}}};
        end else begin
            return x[DW-1:0];
        end
    endfunction

    // Offset-style encoding expected by the DAC: keep sign, invert magnitude.
    function automatic logic [DW-1:0] enc(input logic [DW-1:0] s);
        return {s[DW-1], ~s[DW-2:0]};
    endfunction

    // ------------------------------------------------------------------ FIFO
    logic [IW-1:0] r_mem_a [FIFO_DEPTH];
    logic [IW-1:0] r_mem_b [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    logic [IW-1:0] r_held_a;
    logic [IW-1:0] r_held_b;
    logic [DW-1:0] r_dat;
    logic          r_sel;
    logic          r_wrt;
    logic          r_uf;
    logic [15:0]   r_urun_cnt;

    logic          w_push;
    logic          w_pop;
    logic          w_nempty;

    assign s_ready_o = (r_count < DEPTH_C);
    assign w_push    = s_valid_i && s_ready_o;
    assign w_nempty  = (r_count != '0);
    // Frames are only taken when an A word is about to be registered.
    assign w_pop     = w_nempty && (r_state != ST_PH_A);

    // Storage is read asynchronously so a frame can be popped straight into
    // the held registers on the same edge the A word is registered.
    always_ff @(posedge dac_clk_i) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= s_dat_a_i;
            r_mem_b[r_wr_ptr] <= s_dat_b_i;
        end
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------ word generation
    // Source 0 feeds the next A word (fresh frame if popping, else the held
    // one for an underrun); source 1 feeds the B word of the current frame.
    logic [IW-1:0] w_src  [2];
    logic [DW-1:0] w_word [2];

    assign w_src[0] = w_pop ? r_mem_a[r_rd_ptr] : r_held_a;
    assign w_src[1] = r_held_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            assign w_word[gi] = ch_en_i[gi] ? enc(sat(w_src[gi])) : ENC_ZERO;
        end
    endgenerate

    // -------------------------------------------------------------- FSM
    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            r_state    <= ST_IDLE;
            r_held_a   <= '0;
            r_held_b   <= '0;
            r_dat      <= ENC_ZERO;
            r_sel      <= 1'b0;
            r_wrt      <= 1'b1;
            r_uf       <= 1'b0;
            r_urun_cnt <= '0;
        end else begin
            r_uf <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_nempty) begin
                        r_state  <= ST_PH_A;
                        r_held_a <= r_mem_a[r_rd_ptr];
                        r_held_b <= r_mem_b[r_rd_ptr];
                        r_dat    <= w_word[0];
                        r_sel    <= 1'b0;
                        r_wrt    <= 1'b0;
                    end
                end
                ST_PH_A: begin
                    r_state <= ST_PH_B;
                    r_dat   <= w_word[1];
                    r_sel   <= 1'b1;
                    r_wrt   <= 1'b0;
                end
                ST_PH_B: begin
                    r_state <= ST_PH_A;
                    r_dat   <= w_word[0];
                    r_sel   <= 1'b0;
                    r_wrt   <= 1'b0;
                    if (w_pop) begin
                        r_held_a <= r_mem_a[r_rd_ptr];
                        r_held_b <= r_mem_b[r_rd_ptr];
                    end else begin
                        // Source stalled: repeat the held frame and flag it.
                        r_uf <= 1'b1;
                        if (r_urun_cnt != 16'hFFFF) begin
                            r_urun_cnt <= r_urun_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dac_dat_o   = r_dat;
    assign dac_sel_o   = r_sel;
    assign dac_wrt_o   = r_wrt;
    assign underflow_o = r_uf;
    assign urun_cnt_o  = r_urun_cnt;

endmodule

// File: tb/tb_dac_interleaver.sv
// -----------------------------------------------------------------------------
// tb_dac_interleaver
//
// Directed bench for dac_interleaver: reset values, a table of single-frame
// saturation/encoding/enable vectors, an underrun sequence, a back-to-back
// streaming run with ordering and buffer-depth checks, and an asynchronous
// reset asserted between clock edges.
// -----------------------------------------------------------------------------
module tb_dac_interleaver;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        valid = 1'b0;
    logic        ready;
    logic [1:0]  en    = 2'b11;
    logic [13:0] dat;
    logic        sel;
    logic        wrt;
    logic        uf;
    logic [15:0] cnt;

    int checks   = 0;
    int failures = 0;

    int n_acc    = 0;
    int m_a      = 0;
    int m_b      = 0;
    int max_buf  = 0;
    logic saw_ready_low = 1'b0;

    always #5 clk = ~clk;

    dac_interleaver #(
        .DW         (14),
        .IW         (16),
        .FIFO_DEPTH (4)
    ) dut (
        .dac_clk_i   (clk),
        .dac_rst_i   (rst),
        .s_dat_a_i   (a),
        .s_dat_b_i   (b),
        .s_valid_i   (valid),
        .s_ready_o   (ready),
        .ch_en_i     (en),
        .dac_dat_o   (dat),
        .dac_sel_o   (sel),
        .dac_wrt_o   (wrt),
        .underflow_o (uf),
        .urun_cnt_o  (cnt)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  en;
        logic [13:0] exp_a;
        logic [13:0] exp_b;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    // Presents one frame for exactly one rising edge.
    task automatic push_one(input logic [15:0] fa, input logic [15:0] fb, input logic [1:0] fen);
        @(negedge clk);
        a     = fa;
        b     = fb;
        en    = fen;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            a         b         en     A word    B word
        vecs[0] = '{16'h0064, 16'hFF9C, 2'b11, 14'h1F9B, 14'h2063}; // 100 / -100
        vecs[1] = '{16'h7FFF, 16'h8000, 2'b11, 14'h0000, 14'h3FFF}; // clamp both
        vecs[2] = '{16'h0000, 16'h01F4, 2'b01, 14'h1FFF, 14'h1FFF}; // B disabled
        vecs[3] = '{16'h1FFF, 16'hE000, 2'b11, 14'h0000, 14'h3FFF}; // exact limits
        vecs[4] = '{16'h2000, 16'hDFFF, 2'b11, 14'h0000, 14'h3FFF}; // one past
        vecs[5] = '{16'hFFFF, 16'h0001, 2'b11, 14'h2000, 14'h1FFE}; // -1 / 1
        vecs[6] = '{16'h007B, 16'hFFFB, 2'b10, 14'h1FFF, 14'h2004}; // A disabled
        vecs[7] = '{16'h01F4, 16'h01F4, 2'b01, 14'h1E0B, 14'h1FFF}; // 500 / B off

        // ---------------- reset values
        @(negedge clk);
        chk("rst_dat", dat, 14'h1FFF);
        chk("rst_sel", sel, 1'b0);
        chk("rst_wrt", wrt, 1'b1);
        chk("rst_uf", uf, 1'b0);
        chk("rst_cnt", cnt, 16'h0000);
        chk("rst_ready", ready, 1'b1);
        rst = 1'b0;

        // ---------------- single-frame vectors
        for (int i = 0; i < 8; i++) begin
            do_reset();
            push_one(vecs[i].a, vecs[i].b, vecs[i].en);
            @(negedge clk);
            chk($sformatf("v%0d_a_dat", i), dat, vecs[i].exp_a);
            chk($sformatf("v%0d_a_sel", i), sel, 1'b0);
            chk($sformatf("v%0d_a_wrt", i), wrt, 1'b0);
            chk($sformatf("v%0d_a_uf", i), uf, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_b_dat", i), dat, vecs[i].exp_b);
            chk($sformatf("v%0d_b_sel", i), sel, 1'b1);
            chk($sformatf("v%0d_b_wrt", i), wrt, 1'b0);
            $display("vec %0d a=0x%04h b=0x%04h en=%b -> A=0x%04h B=0x%04h",
                     i, vecs[i].a, vecs[i].b, vecs[i].en, vecs[i].exp_a, vecs[i].exp_b);
        end

        // ---------------- underrun: one frame then the source stops
        do_reset();
        push_one(16'h0064, 16'hFF9C, 2'b11);
        @(negedge clk);
        chk("ur0_a_dat", dat, 14'h1F9B);
        chk("ur0_a_uf", uf, 1'b0);
        chk("ur0_a_cnt", cnt, 16'd0);
        @(negedge clk);
        chk("ur0_b_dat", dat, 14'h2063);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk($sformatf("ur%0d_a_dat", j), dat, 14'h1F9B);
            chk($sformatf("ur%0d_a_sel", j), sel, 1'b0);
            chk($sformatf("ur%0d_a_uf", j), uf, 1'b1);
            chk($sformatf("ur%0d_a_cnt", j), cnt, 16'(j));
            @(negedge clk);
            chk($sformatf("ur%0d_b_dat", j), dat, 14'h2063);
            chk($sformatf("ur%0d_b_sel", j), sel, 1'b1);
            chk($sformatf("ur%0d_b_uf", j), uf, 1'b0);
            chk($sformatf("ur%0d_b_cnt", j), cnt, 16'(j));
            $display("underrun %0d count=%0d", j, cnt);
        end

        // ---------------- streaming 0..63 with valid held high
        // Frame n: a = n -> A word 0x1FFF-n ; b = -(n+1) -> B word 0x2000|n
        do_reset();
        en    = 2'b11;
        n_acc = 0;
        m_a   = 0;
        m_b   = 0;
        fork
            begin : drv
                logic acc;
                for (int it = 0; it < 400 && n_acc < 64; it++) begin
                    @(negedge clk);
                    a     = 16'(n_acc);
                    b     = ~16'(n_acc);
                    valid = 1'b1;
                    acc   = ready;
                    if (!ready) saw_ready_low = 1'b1;
                    @(posedge clk);
                    if (acc) n_acc++;
                end
                @(negedge clk);
                valid = 1'b0;
            end
            begin : mon
                for (int c = 0; c < 400 && m_b < 64; c++) begin
                    @(negedge clk);
                    chk("stream_uf", uf, 1'b0);
                    if (!wrt && !sel) begin
                        chk($sformatf("stream_a%0d", m_a), dat, 14'h1FFF - 14'(m_a));
                        m_a++;
                    end else if (!wrt && sel) begin
                        chk($sformatf("stream_b%0d", m_b), dat, 14'h2000 | 14'(m_b));
                        $display("stream frame %0d A/B delivered dat_b=0x%04h", m_b, dat);
                        m_b++;
                    end
                    if (n_acc - m_a > max_buf) max_buf = n_acc - m_a;
                end
                if (m_b < 64) chk("stream_timeout", m_b, 64);
            end
        join
        chk("stream_max_buffered", max_buf, 4);
        chk("stream_ready_dropped", saw_ready_low, 1'b1);
        chk("stream_accepted", n_acc, 64);

        // ---------------- reset asserted between edges mid-operation
        repeat (4) @(negedge clk);
        chk("pre_rst_cnt", cnt, 16'd2);
        a     = 16'h0007;
        b     = 16'h0007;
        valid = 1'b1;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dat", dat, 14'h1FFF);
        chk("async_rst_sel", sel, 1'b0);
        chk("async_rst_wrt", wrt, 1'b1);
        chk("async_rst_uf", uf, 1'b0);
        chk("async_rst_cnt", cnt, 16'd0);
        chk("async_rst_ready", ready, 1'b1);
        $display("async reset applied mid-stream");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle_wrt%0d", k), wrt, 1'b1);
            chk($sformatf("post_rst_idle_dat%0d", k), dat, 14'h1FFF);
        end
        push_one(16'h0064, 16'hFF9C, 2'b11);
        @(negedge clk);
        chk("post_rst_a_dat", dat, 14'h1F9B);
        chk("post_rst_a_wrt", wrt, 1'b0);
        @(negedge clk);
        chk("post_rst_b_dat", dat, 14'h2063);
        chk("post_rst_b_sel", sel, 1'b1);
        $display("post-reset frame A=0x1F9B B=0x2063 expected");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_interleaver.md
# dac_interleaver

Upstream feed stage for the two-channel DAC port. It accepts paired channel A/B samples from the signal generator through a valid/ready handshake and buffers them in a small frame FIFO. It saturates and encodes each sample, then time-multiplexes them onto the single 14-bit DAC data bus with the select and active-low write strobes that the DAC driver consumes. It also detects and counts underruns, and holds the last frame when the source stalls.

## Interface
- `DW`, 14, DAC data width.
- `IW`, 16, input sample width (signed two's complement).
- `FIFO_DEPTH`, 4, frame FIFO depth; must be a power of 2, at least 2.
- `dac_clk_i`  in  1  DAC clock; the block uses this one clock only.
- `dac_rst_i`  in  1  reset; asynchronous, active-high.
- `s_dat_a_i`  in  IW  channel A sample.
- `s_dat_b_i`  in  IW  channel B sample.
- `s_valid_i`  in  1  frame (A+B pair) valid.
- `s_ready_o`  out  1  FIFO can accept a frame.
- `ch_en_i`  in  2  per-channel enable; bit 0 = A, bit 1 = B.
- `dac_dat_o`  out  DW  encoded DAC data.
- `dac_sel_o`  out  1  0 = channel A word, 1 = channel B word.
- `dac_wrt_o`  out  1  write strobe, active low.
- `underflow_o`  out  1  one-cycle pulse on each underrun.
- `urun_cnt_o`  out  16  saturating underrun count.

## Operation
- **Handshake:** a frame transfers when `s_valid_i && s_ready_o`. `s_ready_o = (count < FIFO_DEPTH)`, decoded from the registered count.
- **FIFO:** stores `{a,b}` frames. A pop happens only when `count > 0` (no fall-through). A push and a pop in the same cycle leave `count` unchanged.
- **Saturation:** input is signed `IW`; clamp to [-2^(DW-1), 2^(DW-1)-1] (-8192..8191 for defaults).
- **Encoding:** `enc(x) = {x[DW-1], ~x[DW-2:0]}`. A disabled channel outputs `enc(0) = 0x1FFF`.
- **FSM states, each naming what is presented on the outputs:**
  - IDLE: `dac_wrt_o = 1`, `dac_sel_o = 0`, `dac_dat_o = 0x1FFF`.
  - PH_A: `dac_wrt_o = 0`, `dac_sel_o = 0`, `dac_dat_o = enc(sat(held_a))`.
  - PH_B: `dac_wrt_o = 0`, `dac_sel_o = 1`, `dac_dat_o = enc(sat(held_b))`.
- **Transitions:**
  - IDLE -> PH_A when `count > 0`: pop the frame into the held registers. Otherwise stay in IDLE.
  - PH_A -> PH_B always.
  - PH_B -> PH_A always. Pop if `count > 0`. If `count == 0`, re-present the held frame, assert `underflow_o` for the cycle PH_A is entered, and increment `urun_cnt_o`. The counter saturates at 0xFFFF and does not wrap.
- Once running, the block never returns to IDLE except through reset.
- `ch_en_i` is sampled when each word is registered; a change takes effect on the next word.

## Timing
- All outputs are registered.
- Reset values: `dac_dat_o = 0x1FFF`, `dac_sel_o = 0`, `dac_wrt_o = 1`, `underflow_o = 0`, `urun_cnt_o = 0`, FSM = IDLE, FIFO empty, held frame = 0. With FIFO empty after reset, `s_ready_o = 1`.
- Latency: a frame accepted at edge k (first frame, FSM in IDLE) appears as A after edge k+1 and as B after edge k+2.
- Throughput: one frame per 2 cycles. `s_ready_o` drops after `FIFO_DEPTH` frames are buffered while the output is draining.
- Reset asserted mid-operation: outputs, FIFO and counter go to reset values immediately (asynchronous). The first frame after deassertion follows the IDLE latency above.
- Underflow: checked only on the PH_B->PH_A edge. PH_A->PH_B never pops and never flags.

## Test plan
- Reset, then push frame a=100, b=-100, both channels enabled -> after k+1: `dat = enc(100) = 0x1F9B`, `sel = 0`, `wrt = 0`; after k+2: `dat = enc(-100) = 0x2063`, `sel = 1`.
- Push a=32767, b=-32768 -> a clamps to 8191 (`0x0000`), b clamps to -8192 (`0x3FFF`).
- Push 1 frame and then stop -> A/B alternate with the held values; `underflow_o` pulses every 2 cycles; `urun_cnt_o` increments 1, 2, 3...
- Hold `s_valid_i` high with the output draining -> at most 4 frames buffered; `s_ready_o` toggles to sustain 1 frame per 2 cycles; no frame lost or duplicated (sequence 0..63 checked in order).
- `ch_en_i = 2'b01` with b = 500 -> B words read `0x1FFF`, A words unaffected.
- Assert `dac_rst_i` mid-stream between edges -> outputs go to reset values before the next edge; FIFO flushed; count 0.
